// File: rtl/select_sequencer.sv
// Two-button (up/down) select generator for the 4:1 LED mux: sync, debounce, press-edge, wrap counter.
// Optional auto-scan stepping is compiled in with `define SELECT_AUTOSCAN_EN.
module select_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCAN_PERIOD     = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_dn,
`ifdef SELECT_AUTOSCAN_EN
  input  logic       auto_en,
`endif
  output logic [1:0] select,
  output logic       step
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || SCAN_PERIOD < 2) begin : g_bad_params
    $error("select_sequencer: DEBOUNCE_CYCLES and SCAN_PERIOD must be >= 2");
  end

  // Bit 0 carries the up button, bit 1 the down button through the whole path.
  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           stable_q, stable_d, stable_dly_q;
  logic [1:0][DB_W-1:0] cnt_q, cnt_d;
  logic [1:0]           press;
  logic                 up_ev, dn_ev, tick;
  logic [1:0]           select_q, select_d;
  logic                 step_q, step_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DB_LAST) stable_d[i] = sync2_q[i];
        else                     cnt_d[i]    = cnt_q[i] + 1'b1;
      end
    end
  end

  assign press = stable_q & ~stable_dly_q;
  assign up_ev = press[0];
  assign dn_ev = press[1];

`ifdef SELECT_AUTOSCAN_EN
  localparam int SC_W = $clog2(SCAN_PERIOD);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_PERIOD - 1);

  logic [SC_W-1:0] scan_q, scan_d;

  // A button event restarts the scan interval so manual steps are not followed by an early tick.
  always_comb begin
    scan_d = '0;
    tick   = 1'b0;
    if (auto_en && !(up_ev || dn_ev)) begin
      if (scan_q == SC_LAST) tick   = 1'b1;
      else                   scan_d = scan_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scan_q <= '0;
    else        scan_q <= scan_d;
  end
`else
  assign tick = 1'b0;
`endif

  always_comb begin
    select_d = select_q;
    step_d   = 1'b0;
    if (up_ev && !dn_ev) begin
      select_d = select_q + 2'd1;
      step_d   = 1'b1;
    end else if (dn_ev && !up_ev) begin
      select_d = select_q - 2'd1;
      step_d   = 1'b1;
    end else if (!up_ev && !dn_ev && tick) begin
      select_d = select_q + 2'd1;
      step_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      cnt_q        <= '0;
      select_q     <= 2'b00;
      step_q       <= 1'b0;
    end else begin
      sync1_q      <= {btn_dn, btn_up};
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
      select_q     <= select_d;
      step_q       <= step_d;
    end
  end

  assign select = select_q;
  assign step   = step_q;

endmodule

// File: tb/tb_select_sequencer.sv
// Directed bench for select_sequencer with DEBOUNCE_CYCLES=4, SCAN_PERIOD=8.
// Auto-scan scenarios are included when SELECT_AUTOSCAN_EN is defined.
module tb_select_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_up, btn_dn;
  logic       auto_en;
  logic [1:0] select;
  logic       step;

  int errs   = 0;
  int checks = 0;
  int st;

  select_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .SCAN_PERIOD    (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_up (btn_up),
    .btn_dn (btn_dn),
`ifdef SELECT_AUTOSCAN_EN
    .auto_en(auto_en),
`endif
    .select (select),
    .step   (step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, output int steps);
    steps = 0;
    repeat (n) begin
      cyc();
      if (step === 1'b1) steps++;
    end
  endtask

  // Caller has just driven the button; the next edge is k. Update lands at k+6.
  task automatic exact_seq(input logic [1:0] old_sel, input logic [1:0] new_sel, input string tag);
    repeat (6) cyc();
    chk({tag, "_pre_sel"}, select, old_sel);
    chk({tag, "_pre_step"}, step, 1'b0);
    cyc();
    chk({tag, "_sel"}, select, new_sel);
    chk({tag, "_step"}, step, 1'b1);
    cyc();
    chk({tag, "_step_drop"}, step, 1'b0);
  endtask

  task automatic press(input logic up, input logic dn, input logic [1:0] exp_sel,
                       input int exp_steps, input string tag);
    int s1, s2;
    btn_up = up;
    btn_dn = dn;
    run(10, s1);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    run(8, s2);
    chk({tag, "_steps"}, s1 + s2, exp_steps);
    chk({tag, "_sel"}, select, exp_sel);
  endtask

  initial begin
    rst_n   = 1'b0;
    btn_up  = 1'b0;
    btn_dn  = 1'b0;
    auto_en = 1'b0;

    repeat (3) cyc();
    chk("rst_sel", select, 2'd0);
    chk("rst_step", step, 1'b0);
    rst_n = 1'b1;
    run(20, st);
    chk("idle_steps", st, 0);
    chk("idle_sel", select, 2'd0);

    // Clean press with exact latency, then hold without repeat
    btn_up = 1'b1;
    exact_seq(2'd0, 2'd1, "up1");
    run(2, st);
    btn_up = 1'b0;
    begin
      int s2;
      run(8, s2);
      chk("up1_hold_steps", st + s2, 0);
    end

    press(1'b1, 1'b0, 2'd2, 1, "up2");
    press(1'b1, 1'b0, 2'd3, 1, "up3");
    press(1'b1, 1'b0, 2'd0, 1, "up_wrap");
    press(1'b0, 1'b1, 2'd3, 1, "dn_wrap");

    // Short glitch
    btn_up = 1'b1;
    repeat (3) cyc();
    btn_up = 1'b0;
    run(10, st);
    chk("glitch_steps", st, 0);
    chk("glitch_sel", select, 2'd3);

    // Bouncy edge 1,1,0 then steady high
    btn_up = 1'b1;
    cyc();
    cyc();
    btn_up = 1'b0;
    cyc();
    btn_up = 1'b1;
    exact_seq(2'd3, 2'd0, "bounce");
    run(4, st);
    btn_up = 1'b0;
    begin
      int s2;
      run(8, s2);
      chk("bounce_extra_steps", st + s2, 0);
    end

    press(1'b1, 1'b1, 2'd0, 0, "both");

    // Reset while a held press is registered; press counts again after release
    btn_up = 1'b1;
    exact_seq(2'd0, 2'd1, "pre_rst");
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sel", select, 2'd0);
    chk("async_rst_step", step, 1'b0);
    cyc();
    rst_n = 1'b1;
    exact_seq(2'd0, 2'd1, "held_thru_rst");
    btn_up = 1'b0;
    run(8, st);
    chk("held_release_steps", st, 0);

    // Reset in the middle of a debounce count discards it
    btn_dn = 1'b1;
    repeat (4) cyc();
    #2;
    rst_n = 1'b0;
    cyc();
    rst_n  = 1'b1;
    btn_dn = 1'b0;
    run(12, st);
    chk("mid_db_rst_steps", st, 0);
    chk("mid_db_rst_sel", select, 2'd0);

`ifdef SELECT_AUTOSCAN_EN
    auto_en = 1'b1;
    for (int t = 0; t < 4; t++) begin
      logic [1:0] prev;
      prev = 2'(t);
      repeat (7) cyc();
      chk($sformatf("scan%0d_pre_sel", t), select, prev);
      chk($sformatf("scan%0d_pre_step", t), step, 1'b0);
      cyc();
      chk($sformatf("scan%0d_sel", t), select, prev + 2'd1);
      chk($sformatf("scan%0d_step", t), step, 1'b1);
    end
    // Down press timed to land on the next scan tick
    cyc();
    btn_dn = 1'b1;
    exact_seq(2'd0, 2'd3, "scan_dn");
    btn_dn = 1'b0;
    repeat (6) cyc();
    chk("scan_after_dn_pre_sel", select, 2'd3);
    chk("scan_after_dn_pre_step", step, 1'b0);
    cyc();
    chk("scan_after_dn_sel", select, 2'd0);
    chk("scan_after_dn_step", step, 1'b1);
    auto_en = 1'b0;
    run(20, st);
    chk("scan_off_steps", st, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
